// File: rtl/mips32_fetch_unit_if.sv
// Signal bundle between the fetch unit, the instruction memory and the core.
// The master modport is the fetch unit; the slave modport is the environment
// (instruction memory plus the core's decode/redirect side).
interface mips32_fetch_unit_if;
  // instruction memory read port
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  // control-flow redirect from the core
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // instruction issue handshake towards the core
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  // current fetch PC
  logic [31:0] pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready,
    output pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready,
    input  pc
  );
endinterface

// File: rtl/mips32_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one word read at a time
// to a variable-latency instruction memory, buffers returned words with
// their PC in a small FIFO and hands them to the core over valid/ready.
// Redirects from the core flush the buffer and retarget the fetch PC; a
// request already on the memory bus is never withdrawn, its response is
// simply discarded.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no request outstanding
// WAIT  | request outstanding, response will be pushed into the FIFO
// DROP  | request outstanding, response will be discarded (redirected)
module mips32_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  mips32_fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0] fetch_pc;
  logic [31:0] req_addr;
  logic        req;

  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [31:0]      fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic             redirect;
  logic [31:0]      redirect_target;
  logic             pop;
  logic [CNT_W-1:0] occupancy_after_pop;
  logic             has_room;
  logic             issue;
  logic             push;
  logic             retire;
  logic             unused_redirect_lsbs;

  assign redirect        = bus.redirect_valid;
  assign redirect_target = {bus.redirect_pc[31:2], 2'b00};
  // the low address bits of a redirect target are forced to zero
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  assign pop = (count != '0) && bus.inst_ready;

  // An outstanding request always has a slot reserved for it, because a
  // request is only issued from IDLE when the FIFO has room after this
  // cycle's pop. Overflow therefore cannot happen.
  assign occupancy_after_pop = count - CNT_W'(pop);
  assign has_room            = occupancy_after_pop < CNT_W'(FIFO_DEPTH);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    retire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!redirect && has_room) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_ack) begin
          retire    = 1'b1;
          push      = !redirect;
          state_nxt = IDLE;
        end else if (redirect) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (bus.imem_ack) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Memory request: address is captured at issue and held until the ack,
  // even across a redirect, since the bus cannot retract a request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req      <= 1'b0;
      req_addr <= RESET_PC;
    end else if (issue) begin
      req      <= 1'b1;
      req_addr <= fetch_pc;
    end else if (retire) begin
      req      <= 1'b0;
    end
  end

  // Fetch PC: a redirect overrides the sequential advance of an accepted word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_target;
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer outright
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage; cleared on reset so the head reads as zero afterwards
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (push) begin
      fifo_data[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr]   <= fetch_pc;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = req_addr;
  assign bus.pc         = fetch_pc;
  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = fifo_data[rd_ptr];
  assign bus.inst_pc    = fifo_pc[rd_ptr];

endmodule

// File: tb/tb_mips32_fetch_unit.sv
// Directed and randomized bench for mips32_fetch_unit. A transaction-level
// reference keeps the expected fetch address and the queue of instructions
// the core should see, updated from the observed bus traffic.
module tb_mips32_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  mips32_fetch_unit_if bus();

  mips32_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  int checks = 0;
  int errors = 0;

  entry_t      exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] f_exp;
  logic        poison;
  logic        prev_active;
  logic [31:0] held_addr;
  int          wait_cnt;
  int          lat;
  int          kept_acks;
  logic        rand_lat;

  logic        drv_ready;
  logic        drv_redir;
  logic        drv_stale;
  logic [31:0] drv_tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    req_log.delete();
    f_exp       = RESET_PC;
    poison      = 1'b0;
    prev_active = 1'b0;
    held_addr   = RESET_PC;
    wait_cnt    = 0;
    kept_acks   = 0;
    drv_redir   = 1'b0;
    drv_stale   = 1'b0;
    drv_tgt     = '0;
  endtask

  // Assert reset (may be called at any time), check reset outputs, hold two
  // edges, then release just after a rising edge.
  task automatic apply_reset();
    reset_n            = 1'b0;
    bus.imem_ack       = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    #1;
    chk1("rst_imem_req",   bus.imem_req,   1'b0);
    chk ("rst_imem_addr",  bus.imem_addr,  RESET_PC);
    chk ("rst_pc",         bus.pc,         RESET_PC);
    chk1("rst_inst_valid", bus.inst_valid, 1'b0);
    chk ("rst_inst_data",  bus.inst_data,  32'h0);
    chk ("rst_inst_pc",    bus.inst_pc,    32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs against the reference,
  // advance the reference, then step past the next rising edge.
  task automatic tick();
    logic        req;
    logic        ack;
    logic [31:0] addr;
    logic [31:0] data;
    entry_t      e;
    req  = bus.imem_req;
    addr = bus.imem_addr;
    ack  = (req && (wait_cnt >= lat - 1)) || drv_stale;
    data = req ? mem_word(addr) : 32'hBAD0_BAD0;
    bus.imem_ack       = ack;
    bus.imem_rdata     = data;
    bus.inst_ready     = drv_ready;
    bus.redirect_valid = drv_redir;
    bus.redirect_pc    = drv_tgt;

    chk ("pc", bus.pc, f_exp);
    chk1("inst_valid", bus.inst_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("inst_pc",   bus.inst_pc,   exp_q[0].pc);
      chk("inst_data", bus.inst_data, exp_q[0].data);
    end
    if (prev_active) begin
      chk1("req_held",  req,  1'b1);
      chk ("addr_hold", addr, held_addr);
    end else if (req) begin
      chk ("req_addr",   addr, f_exp);
      chk1("issue_room", exp_q.size() < DEPTH, 1'b1);
      req_log.push_back(addr);
    end

    if (drv_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    if (req && ack) begin
      if (!poison && !drv_redir) begin
        e.pc   = addr;
        e.data = data;
        exp_q.push_back(e);
        f_exp = f_exp + 32'd4;
        kept_acks++;
      end
      poison = 1'b0;
      if (rand_lat) lat = $urandom_range(1, 4);
    end
    if (drv_redir) begin
      exp_q.delete();
      f_exp = {drv_tgt[31:2], 2'b00};
      if (req && !ack) poison = 1'b1;
    end
    chk1("fifo_bound", exp_q.size() <= DEPTH, 1'b1);
    prev_active = req && !ack;
    held_addr   = addr;

    @(posedge clk);
    #1;
    wait_cnt  = (req && !ack) ? wait_cnt + 1 : 0;
    drv_redir = 1'b0;
    drv_stale = 1'b0;
  endtask

  task automatic run_until_req(input int max_cycles);
    int n;
    n = 0;
    while (!bus.imem_req && n < max_cycles) begin
      tick();
      n++;
    end
    chk1("req_timeout", bus.imem_req, 1'b1);
  endtask

  initial begin
    int n;
    lat       = 1;
    rand_lat  = 1'b0;
    drv_ready = 1'b0;
    model_reset();

    // 1: sequential fetch, 1-cycle memory; first valid in the third cycle
    //    after release (release cycle counts as cycle 1)
    apply_reset();
    drv_ready = 1'b1;
    chk1("t1_valid_c1", bus.inst_valid, 1'b0);
    tick();
    chk1("t1_valid_c2", bus.inst_valid, 1'b0);
    tick();
    chk1("t1_valid_c3", bus.inst_valid, 1'b1);
    repeat (8) tick();
    chk1("t1_nreq", req_log.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) chk("t1_addr_seq", req_log[i], 32'(i * 4));

    // 2: core stalled -> two accepted, then fetch stops at pc 8; drain resumes
    apply_reset();
    drv_ready = 1'b0;
    lat       = 1;
    repeat (12) tick();
    chk ("t2_kept",  32'(kept_acks), 32'd2);
    chk1("t2_req",   bus.imem_req,   1'b0);
    chk ("t2_pc",    bus.pc,         32'h8);
    chk ("t2_head0", bus.inst_pc,    32'h0);
    drv_ready = 1'b1;
    tick();
    chk ("t2_head1", bus.inst_pc,    32'h4);
    repeat (4) tick();
    chk1("t2_nreq", req_log.size() >= 3, 1'b1);
    chk ("t2_resume", req_log[2], 32'h8);

    // 3: redirect while waiting on a 4-cycle memory -> DROP, then target
    apply_reset();
    drv_ready = 1'b1;
    lat       = 4;
    run_until_req(5);
    tick();
    drv_redir = 1'b1;
    drv_tgt   = 32'h0000_0103;
    tick();
    chk1("t3_req_held",  bus.imem_req,  1'b1);
    chk ("t3_addr_held", bus.imem_addr, 32'h0);
    chk ("t3_pc",        bus.pc,        32'h100);
    repeat (12) tick();
    chk1("t3_nreq", req_log.size() >= 2, 1'b1);
    chk ("t3_target", req_log[1], 32'h100);

    // 4a: redirect in the same cycle as the ack
    apply_reset();
    drv_ready = 1'b1;
    lat       = 3;
    run_until_req(5);
    n = 0;
    while (!(bus.imem_req && wait_cnt >= lat - 1) && n < 10) begin
      tick();
      n++;
    end
    drv_redir = 1'b1;
    drv_tgt   = 32'h0000_0200;
    tick();
    chk1("t4a_valid", bus.inst_valid, 1'b0);
    chk1("t4a_req",   bus.imem_req,   1'b0);
    repeat (6) tick();
    chk1("t4a_nreq", req_log.size() >= 2, 1'b1);
    chk ("t4a_target", req_log[1], 32'h200);

    // 4b: redirect in the same cycle as a pop from a full FIFO
    apply_reset();
    drv_ready = 1'b0;
    lat       = 1;
    repeat (8) tick();
    chk("t4b_kept", 32'(kept_acks), 32'd2);
    drv_ready = 1'b1;
    drv_redir = 1'b1;
    drv_tgt   = 32'h0000_0302;
    tick();
    chk1("t4b_valid", bus.inst_valid, 1'b0);
    repeat (4) tick();
    chk1("t4b_nreq", req_log.size() >= 3, 1'b1);
    chk ("t4b_target", req_log[2], 32'h300);

    // 5: fetch across the top of the address space
    apply_reset();
    drv_ready = 1'b1;
    lat       = 1;
    drv_redir = 1'b1;
    drv_tgt   = 32'hFFFF_FFFC;
    tick();
    repeat (8) tick();
    chk1("t5_nreq", req_log.size() >= 2, 1'b1);
    chk ("t5_addr0", req_log[0], 32'hFFFF_FFFC);
    chk ("t5_addr1", req_log[1], 32'h0000_0000);

    // 6: reset mid-WAIT; the late ack lands after release and is ignored
    apply_reset();
    drv_ready = 1'b1;
    lat       = 4;
    run_until_req(5);
    tick();
    @(negedge clk);
    apply_reset();
    drv_stale = 1'b1;
    tick();
    chk1("t6_req",  bus.imem_req,  1'b1);
    chk ("t6_addr", bus.imem_addr, RESET_PC);
    repeat (8) tick();
    chk("t6_kept", 32'(kept_acks >= 1), 32'd1);

    // randomized traffic: latency, back-pressure, redirects, stray acks
    apply_reset();
    rand_lat = 1'b1;
    lat      = 2;
    for (int c = 0; c < 3000; c++) begin
      drv_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        drv_redir = 1'b1;
        if ($urandom_range(0, 3) == 0) drv_tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else drv_tgt = $urandom;
      end
      if ($urandom_range(0, 31) == 0 && !bus.imem_req) drv_stale = 1'b1;
      tick();
    end
    chk1("rand_progress", kept_acks > 100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
